// File: rtl/regcheck_monitor.sv
// Self-check monitor: watches register-file writes and the retire stream,
// then latches a sticky PASS / FAIL / TIMEOUT verdict with failure context.
module regcheck_monitor #(
   parameter int          XLEN           = 32,
   parameter int          PC_WIDTH       = 32,
   parameter int          CHECK_REG      = 31,
   parameter int          TEST_ID_REG    = 1,
   parameter int          MAX_RETIRE     = 1024,
   parameter logic [31:0] END_INSTR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 retire_valid,
   input  logic [PC_WIDTH-1:0]  retire_pc,
   input  logic [31:0]          retire_instr,
   input  logic                 rf_we,
   input  logic [4:0]           rf_waddr,
   input  logic [XLEN-1:0]      rf_wdata,
   output logic                 running,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [XLEN-1:0]      cur_test_id,
   output logic [CNT_WIDTH-1:0] tests_seen,
   output logic [CNT_WIDTH-1:0] retired,
   output logic [PC_WIDTH-1:0]  fail_pc,
   output logic [XLEN-1:0]      fail_value,
   output logic [XLEN-1:0]      fail_test_id
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [4:0]           CHECK_IDX   = 5'(CHECK_REG);
   localparam logic [4:0]           TEST_IDX    = 5'(TEST_ID_REG);
   localparam logic [CNT_WIDTH-1:0] RETIRE_LAST = CNT_WIDTH'(MAX_RETIRE - 1);
   localparam logic [IDLE_W-1:0]    IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic [CNT_WIDTH-1:0] tests_seen_q, tests_seen_d;
   logic [XLEN-1:0]      cur_test_id_q, cur_test_id_d;
   logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
   logic [PC_WIDTH-1:0]  fail_pc_q, fail_pc_d;
   logic [XLEN-1:0]      fail_value_q, fail_value_d;
   logic [XLEN-1:0]      fail_test_id_q, fail_test_id_d;
   logic                 running_q, running_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 timeout_q, timeout_d;

   logic wr_ok, chk_bad, id_wr, is_end;

   always_comb begin
      state_d        = state_q;
      retired_d      = retired_q;
      tests_seen_d   = tests_seen_q;
      cur_test_id_d  = cur_test_id_q;
      idle_cnt_d     = idle_cnt_q;
      last_pc_d      = last_pc_q;
      fail_pc_d      = fail_pc_q;
      fail_value_d   = fail_value_q;
      fail_test_id_d = fail_test_id_q;

      // x0 writes never reach the architectural file, so they are invisible here
      wr_ok   = rf_we && (rf_waddr != 5'd0);
      chk_bad = wr_ok && (rf_waddr == CHECK_IDX) && (rf_wdata != '0);
      id_wr   = wr_ok && (rf_waddr == TEST_IDX);
      is_end  = (retire_instr == END_INSTR);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               retired_d    = '0;
               tests_seen_d = '0;
               idle_cnt_d   = '0;
               last_pc_d    = '0;
            end
         end
         S_RUN: begin
            if (retire_valid) begin
               idle_cnt_d = '0;
               last_pc_d  = retire_pc;
               if (!is_end && (retired_q != '1))
                  retired_d = retired_q + 1'b1;
            end else if (idle_cnt_q != IDLE_LAST) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end

            if (id_wr) begin
               cur_test_id_d = rf_wdata;
               if ((rf_wdata != cur_test_id_q) && (tests_seen_q != '1))
                  tests_seen_d = tests_seen_q + 1'b1;
            end

            // Verdict priority: bad check write, then end of program, then stall
            if (chk_bad) begin
               state_d        = S_FAIL;
               fail_pc_d      = retire_pc;
               fail_value_d   = rf_wdata;
               fail_test_id_d = cur_test_id_q;
            end else if (retire_valid && (is_end || (retired_q == RETIRE_LAST))) begin
               state_d = S_PASS;
            end else if (!retire_valid && (idle_cnt_q == IDLE_LAST)) begin
               state_d        = S_TIMEOUT;
               fail_pc_d      = last_pc_q;
               fail_value_d   = '0;
               fail_test_id_d = cur_test_id_q;
            end
         end
         default: ;
      endcase

      running_d = (state_d == S_RUN);
      pass_d    = (state_d == S_PASS);
      timeout_d = (state_d == S_TIMEOUT);
      fail_d    = (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      done_d    = pass_d || fail_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         retired_q      <= '0;
         tests_seen_q   <= '0;
         cur_test_id_q  <= '0;
         idle_cnt_q     <= '0;
         last_pc_q      <= '0;
         fail_pc_q      <= '0;
         fail_value_q   <= '0;
         fail_test_id_q <= '0;
         running_q      <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         retired_q      <= retired_d;
         tests_seen_q   <= tests_seen_d;
         cur_test_id_q  <= cur_test_id_d;
         idle_cnt_q     <= idle_cnt_d;
         last_pc_q      <= last_pc_d;
         fail_pc_q      <= fail_pc_d;
         fail_value_q   <= fail_value_d;
         fail_test_id_q <= fail_test_id_d;
         running_q      <= running_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
         timeout_q      <= timeout_d;
      end
   end

   assign running      = running_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign cur_test_id  = cur_test_id_q;
   assign tests_seen   = tests_seen_q;
   assign retired      = retired_q;
   assign fail_pc      = fail_pc_q;
   assign fail_value   = fail_value_q;
   assign fail_test_id = fail_test_id_q;

endmodule

// File: tb/tb_regcheck_monitor.sv
// Scoreboard bench for regcheck_monitor: directed stimulus queues expected
// output snapshots; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_regcheck_monitor;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [4:0] F_IDLE = 5'b00000;  // {running,done,pass,fail,timeout}
   localparam logic [4:0] F_RUN  = 5'b10000;
   localparam logic [4:0] F_PASS = 5'b01100;
   localparam logic [4:0] F_FAIL = 5'b01010;
   localparam logic [4:0] F_TMO  = 5'b01011;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] retire_instr = NOP;
   logic        rf_we = 1'b0;
   logic [4:0]  rf_waddr = '0;
   logic [31:0] rf_wdata = '0;

   logic        d0_running, d0_done, d0_pass, d0_fail, d0_timeout;
   logic [31:0] d0_cur_id, d0_fpc, d0_fval, d0_fid;
   logic [15:0] d0_seen, d0_ret;
   logic        d8_running, d8_done, d8_pass, d8_fail, d8_timeout;
   logic [31:0] d8_cur_id, d8_fpc, d8_fval, d8_fid;
   logic [15:0] d8_seen, d8_ret;

   regcheck_monitor dut (
      .clk(clk), .reset(reset), .start(start),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .running(d0_running), .done(d0_done), .pass(d0_pass), .fail(d0_fail),
      .timeout(d0_timeout), .cur_test_id(d0_cur_id), .tests_seen(d0_seen),
      .retired(d0_ret), .fail_pc(d0_fpc), .fail_value(d0_fval), .fail_test_id(d0_fid)
   );

   regcheck_monitor #(.MAX_RETIRE(8)) dut8 (
      .clk(clk), .reset(reset), .start(start),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .running(d8_running), .done(d8_done), .pass(d8_pass), .fail(d8_fail),
      .timeout(d8_timeout), .cur_test_id(d8_cur_id), .tests_seen(d8_seen),
      .retired(d8_ret), .fail_pc(d8_fpc), .fail_value(d8_fval), .fail_test_id(d8_fid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      string       name;
      bit          sel;
      logic [4:0]  flags;
      logic [31:0] cur_id;
      logic [15:0] seen;
      logic [15:0] ret;
      logic [31:0] fpc;
      logic [31:0] fval;
      logic [31:0] fid;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
      end
   endtask

   task automatic push_exp(input string name, input bit sel, input logic [4:0] flags,
                           input logic [31:0] cur_id, input logic [15:0] seen,
                           input logic [15:0] ret, input logic [31:0] fpc,
                           input logic [31:0] fval, input logic [31:0] fid);
      exp_t e;
      e.cyc = cyc; e.name = name; e.sel = sel; e.flags = flags;
      e.cur_id = cur_id; e.seen = seen; e.ret = ret;
      e.fpc = fpc; e.fval = fval; e.fid = fid;
      sb_q.push_back(e);
   endtask

   // Monitor: compares each queued snapshot against the selected instance
   exp_t me;
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         me = sb_q.pop_front();
         if (me.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: snapshot missed, cycle %0d required %0d", me.name, cyc, me.cyc);
         end else if (!me.sel) begin
            chk(me.name, "flags", 32'({d0_running, d0_done, d0_pass, d0_fail, d0_timeout}), 32'(me.flags));
            chk(me.name, "cur_test_id", d0_cur_id, me.cur_id);
            chk(me.name, "tests_seen", 32'(d0_seen), 32'(me.seen));
            chk(me.name, "retired", 32'(d0_ret), 32'(me.ret));
            chk(me.name, "fail_pc", d0_fpc, me.fpc);
            chk(me.name, "fail_value", d0_fval, me.fval);
            chk(me.name, "fail_test_id", d0_fid, me.fid);
            $display("txn %s (dut) checked at cycle %0d", me.name, cyc);
         end else begin
            chk(me.name, "flags", 32'({d8_running, d8_done, d8_pass, d8_fail, d8_timeout}), 32'(me.flags));
            chk(me.name, "cur_test_id", d8_cur_id, me.cur_id);
            chk(me.name, "tests_seen", 32'(d8_seen), 32'(me.seen));
            chk(me.name, "retired", 32'(d8_ret), 32'(me.ret));
            chk(me.name, "fail_pc", d8_fpc, me.fpc);
            chk(me.name, "fail_value", d8_fval, me.fval);
            chk(me.name, "fail_test_id", d8_fid, me.fid);
            $display("txn %s (dut8) checked at cycle %0d", me.name, cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
      retire_valid = 1'b1; retire_pc = pc; retire_instr = instr;
      step();
      retire_valid = 1'b0; retire_instr = NOP;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] pc);
      rf_we = 1'b1; rf_waddr = addr; rf_wdata = data; retire_pc = pc;
      step();
      rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Test 1: END_INSTR terminates with PASS, END retire not counted
      do_reset();
      push_exp("reset", 0, F_IDLE, 0, 0, 0, 0, 0, 0);
      do_start();
      push_exp("start", 0, F_RUN, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) retire(32'(i * 4), NOP);
      push_exp("five_retires", 0, F_RUN, 0, 0, 5, 0, 0, 0);
      retire(32'h14, 32'h0000_0000);
      push_exp("end_pass", 0, F_PASS, 0, 0, 5, 0, 0, 0);
      retire(32'h18, NOP);
      push_exp("pass_sticky", 0, F_PASS, 0, 0, 5, 0, 0, 0);

      // Test 2: nonzero x31 write fails with captured context
      do_reset();
      do_start();
      wr(5'd1, 32'd3, 32'h3C);
      push_exp("test_id_3", 0, F_RUN, 3, 1, 0, 0, 0, 0);
      wr(5'd31, 32'h0000_0004, 32'h40);
      push_exp("chk_fail", 0, F_FAIL, 3, 1, 0, 32'h40, 4, 3);
      retire(32'h44, NOP);
      retire(32'h48, 32'h0000_0000);
      push_exp("fail_sticky", 0, F_FAIL, 3, 1, 0, 32'h40, 4, 3);

      // Test 3: test-ID tracking, legal zero write, ignored x0 write
      do_reset();
      do_start();
      wr(5'd1, 32'd1, 32'h0);
      push_exp("id_1", 0, F_RUN, 1, 1, 0, 0, 0, 0);
      wr(5'd1, 32'd1, 32'h4);
      wr(5'd1, 32'd2, 32'h8);
      wr(5'd1, 32'd7, 32'hC);
      push_exp("id_7", 0, F_RUN, 7, 3, 0, 0, 0, 0);
      wr(5'd31, 32'd0, 32'h10);
      push_exp("x31_zero", 0, F_RUN, 7, 3, 0, 0, 0, 0);
      wr(5'd0, 32'd5, 32'h14);
      push_exp("x0_ignored", 0, F_RUN, 7, 3, 0, 0, 0, 0);
      retire(32'h18, 32'h0000_0000);
      push_exp("id_pass", 0, F_PASS, 7, 3, 0, 0, 0, 0);

      // Test 4: FAIL beats PASS in the same cycle
      do_reset();
      do_start();
      rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = 32'h1;
      retire_valid = 1'b1; retire_pc = 32'h80; retire_instr = 32'h0000_0000;
      step();
      rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
      retire_valid = 1'b0; retire_instr = NOP;
      push_exp("fail_over_pass", 0, F_FAIL, 0, 0, 0, 32'h80, 1, 0);

      // Test 5: stall of TIMEOUT_CYCLES cycles after last retire
      do_reset();
      do_start();
      retire(32'h18, NOP);
      retire(32'h1C, NOP);
      repeat (255) step();
      push_exp("stall_255", 0, F_RUN, 0, 0, 2, 0, 0, 0);
      step();
      push_exp("timeout", 0, F_TMO, 0, 0, 2, 32'h1C, 0, 0);

      // Test 6: reset mid-run, pre-start retires, MAX_RETIRE=8 instance
      do_reset();
      do_start();
      for (int i = 0; i < 10; i++) retire(32'(i * 4), NOP);
      push_exp("ten_retires", 0, F_RUN, 0, 0, 10, 0, 0, 0);
      do_reset();
      push_exp("abort_reset", 0, F_IDLE, 0, 0, 0, 0, 0, 0);
      push_exp("abort_reset8", 1, F_IDLE, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) retire(32'(i * 4), NOP);
      push_exp("pre_start", 0, F_IDLE, 0, 0, 0, 0, 0, 0);
      do_start();
      push_exp("start8", 1, F_RUN, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) retire(32'(i * 4), NOP);
      push_exp("seven8", 1, F_RUN, 0, 0, 7, 0, 0, 0);
      retire(32'h1C, NOP);
      push_exp("max_pass8", 1, F_PASS, 0, 0, 8, 0, 0, 0);
      push_exp("eight_run", 0, F_RUN, 0, 0, 8, 0, 0, 0);

      repeat (3) step();
      while (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: snapshot never compared", sb_q[0].name);
         void'(sb_q.pop_front());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regcheck_monitor.md
Name: regcheck_monitor

Overview:
- Synthesizable self-check monitor for the MultipleInstructions core.
- Snoops the register-file write port and the retire stream. It enforces the rule that the check register (x31) must always hold zero, and it tracks the current sub-test ID held in x1.
- Detects end of program and retire stalls, then reports a sticky PASS/FAIL/TIMEOUT verdict with failure context.
- Lets directed assembly tests run unattended in simulation, or on FPGA with the verdict driven to LEDs/UART.

Parameters:
XLEN, 32, register/data width
PC_WIDTH, 32, program counter width
CHECK_REG, 31, register index that must only ever be written with 0
TEST_ID_REG, 1, register index holding the current sub-test number
MAX_RETIRE, 1024, retire count that ends the program (program memory size in words)
END_INSTR, 32'h00000000, instruction encoding treated as end of program
TIMEOUT_CYCLES, 256, max consecutive cycles in RUN with no retire before TIMEOUT
CNT_WIDTH, 16, width of retire/test counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin monitoring
retire_valid  in  1  instruction retired this cycle
retire_pc  in  PC_WIDTH  PC of retired instruction
retire_instr  in  32  retired instruction word
rf_we  in  1  register-file write enable
rf_waddr  in  5  register-file write index
rf_wdata  in  XLEN  register-file write data
running  out  1  state==RUN
done  out  1  state in {PASS,FAIL,TIMEOUT}
pass  out  1  state==PASS
fail  out  1  state in {FAIL,TIMEOUT}
timeout  out  1  state==TIMEOUT
cur_test_id  out  XLEN  last value written to TEST_ID_REG
tests_seen  out  CNT_WIDTH  number of distinct test-ID changes
retired  out  CNT_WIDTH  instructions retired in RUN
fail_pc  out  PC_WIDTH  retire_pc captured at failure
fail_value  out  XLEN  offending CHECK_REG data (0 on timeout)
fail_test_id  out  XLEN  cur_test_id at failure

Behaviour:
- Reset: clk and reset follow the codebase names; reset is synchronous and active-high.
- On reset, state=IDLE and every output is 0. Reset mid-run aborts immediately, with no verdict retained.
- States are IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
- IDLE -> RUN on start. start is ignored in any other state. Counters clear on entry to RUN.
- RUN, evaluated each cycle in priority order:
  1. rf_we && rf_waddr==CHECK_REG && rf_wdata!=0 -> FAIL. Capture fail_pc=retire_pc, fail_value=rf_wdata, fail_test_id=cur_test_id (the pre-update value).
  2. retire_valid && (retire_instr==END_INSTR || retired==MAX_RETIRE-1) -> PASS. The END_INSTR retire is not counted; the MAX_RETIRE-th retire is counted.
  3. Idle counter reaches TIMEOUT_CYCLES-1 with no retire this cycle -> TIMEOUT. Capture fail_pc=last retired PC, fail_value=0.
- Bookkeeping in RUN:
  - retire_valid increments retired, saturating at all-ones, and clears the idle counter.
  - rf_we with rf_waddr==TEST_ID_REG updates cur_test_id next cycle. tests_seen increments only if the new value differs from cur_test_id.
  - Writes with rf_waddr==0 are ignored entirely, even if CHECK_REG or TEST_ID_REG is 0.
  - A CHECK_REG write of 0 is legal.
- Simultaneous events:
  - FAIL wins over PASS and TIMEOUT in the same cycle.
  - A TEST_ID write in the same cycle as a failure updates cur_test_id, but fail_test_id holds the old value.
- In IDLE and terminal states, all inputs are ignored and no counters move.
- Latency: verdict outputs assert the cycle after the triggering edge (registered). All outputs are registered.
- Saturating tests_seen; retired comparison uses CNT_WIDTH bits. CNT_WIDTH must be at least clog2(MAX_RETIRE)+1.

Test Plan:
- Reset, start, 5 retires, then retire_instr=32'h00000000 -> pass=1, done=1, retired=5, fail=0 one cycle later.
- In RUN, rf_we=1, waddr=31, wdata=32'h0000_0004, retire_pc=32'h40, with cur_test_id=3 -> fail=1, fail_pc=32'h40, fail_value=4, fail_test_id=3. Later retires leave these unchanged.
- Writes to x1 with values 1, 1, 2, 7 -> cur_test_id=7, tests_seen=3. A write of 0 to x31 keeps running=1.
- Same cycle: x31 written 32'h1 and retire of END_INSTR -> FAIL, not PASS.
- No retire for TIMEOUT_CYCLES=256 cycles after the last retire at pc=32'h1C -> timeout=1, fail=1, fail_pc=32'h1C, fail_value=0.
- Assert reset while in RUN with retired=10 -> next cycle all outputs 0, state IDLE. Retires before start do not count; MAX_RETIRE=8 with no END_INSTR -> pass on the 8th retire, retired=8.
